// File: rtl/mipsfpga_ahb_cmd_master_if.sv
// Command stream plus AHB-Lite master bus bundle.
// master = the command master, slave = bus/command peer.
interface mipsfpga_ahb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        busy;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    input  HRDATA,
    input  HREADY,
    input  HRESP,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_error,
    output busy,
    output HADDR,
    output HTRANS,
    output HWRITE,
    output HSIZE,
    output HBURST,
    output HWDATA
  );

  modport slave (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    output HRDATA,
    output HREADY,
    output HRESP,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_error,
    input  busy,
    input  HADDR,
    input  HTRANS,
    input  HWRITE,
    input  HSIZE,
    input  HBURST,
    input  HWDATA
  );
endinterface

// File: rtl/mipsfpga_ahb_cmd_master.sv
// AHB-Lite single-transfer master: valid/ready commands
// to pipelined NONSEQ word transfers, one response each.
module mipsfpga_ahb_cmd_master (
  input logic                       HCLK,
  input logic                       HRESET,
  mipsfpga_ahb_cmd_master_if.master bus
);
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  logic        a_valid;
  logic        a_write;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        d_valid;
  logic        d_write;
  logic [31:0] d_wdata;
  logic        err_hold;
  logic        rsp_valid_q;
  logic        rsp_error_q;
  logic [31:0] rsp_rdata_q;

  logic        nonseq;
  logic        accept;
  logic        d_done;

  // err_hold cancels the pipelined address in the
  // second ERROR cycle; A stays put for a reissue.
  assign nonseq = a_valid & ~err_hold;
  assign accept = bus.cmd_valid & bus.cmd_ready;
  assign d_done = d_valid & bus.HREADY;

  assign bus.cmd_ready = ~HRESET & ~err_hold
                       & (~a_valid | bus.HREADY);
  assign bus.HTRANS    = nonseq ? NONSEQ : IDLE;
  assign bus.HADDR     = a_addr & 32'hFFFF_FFFC;
  assign bus.HWRITE    = a_write & a_valid;
  assign bus.HWDATA    = d_wdata;
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.busy      = a_valid | d_valid;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  // Address (A) and data (D) phase stage registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= '0;
    end else begin
      if (bus.HREADY) begin
        d_valid <= nonseq;
        if (nonseq) begin
          d_write <= a_write;
          d_wdata <= a_wdata;
        end
      end
      if (accept) begin
        a_valid <= 1'b1;
        a_write <= bus.cmd_write;
        a_addr  <= bus.cmd_addr;
        a_wdata <= bus.cmd_wdata;
      end else if (bus.HREADY && nonseq) begin
        a_valid <= 1'b0;
      end
    end
  end

  // Track the first cycle of a two-cycle ERROR.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      err_hold <= 1'b0;
    end else if (bus.HREADY) begin
      err_hold <= 1'b0;
    end else if (d_valid && bus.HRESP) begin
      err_hold <= 1'b1;
    end
  end

  // Register one response per completed data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= d_done;
      rsp_error_q <= d_done & bus.HRESP;
      rsp_rdata_q <= (d_done && !d_write)
                   ? bus.HRDATA : 32'h0;
    end
  end
endmodule

// File: tb/tb_mipsfpga_ahb_cmd_master.sv
// Bench for mipsfpga_ahb_cmd_master: directed timing
// scenarios plus a randomized run against a bus slave model.
module tb_mipsfpga_ahb_cmd_master;
  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } cmd_t;

  logic HCLK = 1'b0;
  logic HRESET;
  int   n_chk = 0;
  int   n_pass = 0;

  mipsfpga_ahb_cmd_master_if bus();

  mipsfpga_ahb_cmd_master dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.HRDATA    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    HRESET = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h1234_5678;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    n_chk++; if (bus.HTRANS !== 2'b00) $display("FAIL rst_htrans got %h exp 0", bus.HTRANS); else n_pass++;
    n_chk++; if (bus.HADDR !== 32'h0) $display("FAIL rst_haddr got %h exp 0", bus.HADDR); else n_pass++;
    n_chk++; if (bus.HWRITE !== 1'b0) $display("FAIL rst_hwrite got %b exp 0", bus.HWRITE); else n_pass++;
    n_chk++; if (bus.HWDATA !== 32'h0) $display("FAIL rst_hwdata got %h exp 0", bus.HWDATA); else n_pass++;
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.rsp_rdata !== 32'h0) $display("FAIL rst_rsp_rdata got %h exp 0", bus.rsp_rdata); else n_pass++;
    n_chk++; if (bus.rsp_error !== 1'b0) $display("FAIL rst_rsp_error got %b exp 0", bus.rsp_error); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.cmd_ready !== 1'b0) $display("FAIL rst_cmd_ready got %b exp 0", bus.cmd_ready); else n_pass++;
    n_chk++; if (bus.HSIZE !== 3'b010) $display("FAIL rst_hsize got %b exp 010", bus.HSIZE); else n_pass++;
    n_chk++; if (bus.HBURST !== 3'b000) $display("FAIL rst_hburst got %b exp 000", bus.HBURST); else n_pass++;
    drive_idle();
    next_cyc();
    HRESET = 1'b0;
  endtask

  task automatic test_single_write();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'hBF80_0000;
    bus.cmd_wdata = 32'h0003_FFFF;
    @(negedge HCLK);
    n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL wr_ready got %b exp 1", bus.cmd_ready); else n_pass++;
    next_cyc();
    drive_idle();
    @(negedge HCLK);
    n_chk++; if (bus.HTRANS !== 2'b10) $display("FAIL wr_htrans got %h exp 2", bus.HTRANS); else n_pass++;
    n_chk++; if (bus.HWRITE !== 1'b1) $display("FAIL wr_hwrite got %b exp 1", bus.HWRITE); else n_pass++;
    n_chk++; if (bus.HADDR !== 32'hBF80_0000) $display("FAIL wr_haddr got %h exp bf800000", bus.HADDR); else n_pass++;
    next_cyc();
    @(negedge HCLK);
    n_chk++; if (bus.HWDATA !== 32'h0003_FFFF) $display("FAIL wr_hwdata got %h exp 0003ffff", bus.HWDATA); else n_pass++;
    n_chk++; if (bus.HTRANS !== 2'b00) $display("FAIL wr_idle got %h exp 0", bus.HTRANS); else n_pass++;
    next_cyc();
    @(negedge HCLK);
    n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL wr_rsp_valid got %b exp 1", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.rsp_error !== 1'b0) $display("FAIL wr_rsp_error got %b exp 0", bus.rsp_error); else n_pass++;
    n_chk++; if (bus.rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata got %h exp 0", bus.rsp_rdata); else n_pass++;
    next_cyc();
    @(negedge HCLK);
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL wr_rsp_pulse got %b exp 0", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL wr_busy got %b exp 0", bus.busy); else n_pass++;
    next_cyc();
  endtask

  task automatic test_single_read();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'hBF80_000B;
    next_cyc();
    drive_idle();
    @(negedge HCLK);
    n_chk++; if (bus.HADDR !== 32'hBF80_0008) $display("FAIL rd_haddr got %h exp bf800008", bus.HADDR); else n_pass++;
    n_chk++; if (bus.HWRITE !== 1'b0) $display("FAIL rd_hwrite got %b exp 0", bus.HWRITE); else n_pass++;
    n_chk++; if (bus.HTRANS !== 2'b10) $display("FAIL rd_htrans got %h exp 2", bus.HTRANS); else n_pass++;
    next_cyc();
    bus.HRDATA = 32'h0002_AAAA;
    next_cyc();
    bus.HRDATA = 32'h0;
    @(negedge HCLK);
    n_chk++; if (bus.rsp_valid !== 1'b1) $display("FAIL rd_rsp_valid got %b exp 1", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.rsp_rdata !== 32'h0002_AAAA) $display("FAIL rd_rsp_rdata got %h exp 0002aaaa", bus.rsp_rdata); else n_pass++;
    n_chk++; if (bus.rsp_error !== 1'b0) $display("FAIL rd_rsp_error got %b exp 0", bus.rsp_error); else n_pass++;
    next_cyc();
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd [4];
    for (int i = 0; i < 4; i++) wd[i] = $urandom;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h10 + 4 * c;
        bus.cmd_wdata = wd[c];
      end else begin
        drive_idle();
      end
      @(negedge HCLK);
      if (c < 4) begin
        n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL b2b_ready c%0d got %b exp 1", c, bus.cmd_ready); else n_pass++;
      end
      if (c >= 1 && c <= 4) begin
        n_chk++; if (bus.HTRANS !== 2'b10) $display("FAIL b2b_htrans c%0d got %h exp 2", c, bus.HTRANS); else n_pass++;
        n_chk++; if (bus.HADDR !== 32'h10 + 4 * (c - 1)) $display("FAIL b2b_haddr c%0d got %h exp %h", c, bus.HADDR, 32'h10 + 4 * (c - 1)); else n_pass++;
      end else begin
        n_chk++; if (bus.HTRANS !== 2'b00) $display("FAIL b2b_idle c%0d got %h exp 0", c, bus.HTRANS); else n_pass++;
      end
      if (c >= 2 && c <= 5) begin
        n_chk++; if (bus.HWDATA !== wd[c-2]) $display("FAIL b2b_hwdata c%0d got %h exp %h", c, bus.HWDATA, wd[c-2]); else n_pass++;
      end
      n_chk++; if (bus.rsp_valid !== (c >= 3 && c <= 6)) $display("FAIL b2b_rsp c%0d got %b exp %b", c, bus.rsp_valid, (c >= 3 && c <= 6)); else n_pass++;
      next_cyc();
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd0;
    logic [31:0] rd1;
    rd0 = $urandom;
    rd1 = $urandom;
    for (int c = 0; c < 9; c++) begin
      drive_idle();
      if (c < 2) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h100 + 4 * c;
      end
      bus.HREADY = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
      bus.HRDATA = (c == 5) ? rd0 : (c == 6) ? rd1 : 32'hDEAD_BEEF;
      @(negedge HCLK);
      if (c == 1) begin
        n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL ws_ready_c1 got %b exp 1", bus.cmd_ready); else n_pass++;
      end
      if (c >= 2 && c <= 5) begin
        n_chk++; if (bus.HADDR !== 32'h104) $display("FAIL ws_haddr c%0d got %h exp 104", c, bus.HADDR); else n_pass++;
        n_chk++; if (bus.HTRANS !== 2'b10) $display("FAIL ws_htrans c%0d got %h exp 2", c, bus.HTRANS); else n_pass++;
      end
      if (c >= 2 && c <= 4) begin
        n_chk++; if (bus.cmd_ready !== 1'b0) $display("FAIL ws_ready c%0d got %b exp 0", c, bus.cmd_ready); else n_pass++;
      end
      n_chk++; if (bus.rsp_valid !== (c == 6 || c == 7)) $display("FAIL ws_rsp c%0d got %b exp %b", c, bus.rsp_valid, (c == 6 || c == 7)); else n_pass++;
      if (c == 6) begin
        n_chk++; if (bus.rsp_rdata !== rd0) $display("FAIL ws_rdata0 got %h exp %h", bus.rsp_rdata, rd0); else n_pass++;
      end
      if (c == 7) begin
        n_chk++; if (bus.rsp_rdata !== rd1) $display("FAIL ws_rdata1 got %h exp %h", bus.rsp_rdata, rd1); else n_pass++;
      end
      next_cyc();
    end
    drive_idle();
  endtask

  task automatic test_error();
    logic [31:0] wa;
    logic [31:0] rb;
    wa = $urandom;
    rb = $urandom;
    for (int c = 0; c < 8; c++) begin
      drive_idle();
      if (c == 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 32'h200;
        bus.cmd_wdata = wa;
      end
      if (c == 1) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h204;
      end
      if (c == 2) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = 1'b1;
      end
      if (c == 3) bus.HRESP = 1'b1;
      if (c == 5) bus.HRDATA = rb;
      @(negedge HCLK);
      if (c == 2) begin
        n_chk++; if (bus.HWDATA !== wa) $display("FAIL err_hwdata got %h exp %h", bus.HWDATA, wa); else n_pass++;
        n_chk++; if (bus.HTRANS !== 2'b10) $display("FAIL err_b_first got %h exp 2", bus.HTRANS); else n_pass++;
      end
      if (c == 3) begin
        n_chk++; if (bus.HTRANS !== 2'b00) $display("FAIL err_cancel got %h exp 0", bus.HTRANS); else n_pass++;
        n_chk++; if (bus.cmd_ready !== 1'b0) $display("FAIL err_ready got %b exp 0", bus.cmd_ready); else n_pass++;
      end
      if (c == 4) begin
        n_chk++; if (bus.rsp_error !== 1'b1) $display("FAIL err_rsp_err got %b exp 1", bus.rsp_error); else n_pass++;
        n_chk++; if (bus.rsp_rdata !== 32'h0) $display("FAIL err_rsp_rdata got %h exp 0", bus.rsp_rdata); else n_pass++;
        n_chk++; if (bus.HTRANS !== 2'b10) $display("FAIL err_reissue got %h exp 2", bus.HTRANS); else n_pass++;
        n_chk++; if (bus.HADDR !== 32'h204) $display("FAIL err_reissue_addr got %h exp 204", bus.HADDR); else n_pass++;
        n_chk++; if (bus.HWRITE !== 1'b0) $display("FAIL err_reissue_wr got %b exp 0", bus.HWRITE); else n_pass++;
      end
      if (c == 6) begin
        n_chk++; if (bus.rsp_error !== 1'b0) $display("FAIL err_b_err got %b exp 0", bus.rsp_error); else n_pass++;
        n_chk++; if (bus.rsp_rdata !== rb) $display("FAIL err_b_rdata got %h exp %h", bus.rsp_rdata, rb); else n_pass++;
      end
      if (c >= 3) begin
        n_chk++; if (bus.rsp_valid !== (c == 4 || c == 6)) $display("FAIL err_rsp c%0d got %b exp %b", c, bus.rsp_valid, (c == 4 || c == 6)); else n_pass++;
      end
      if (c == 7) begin
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL err_busy got %b exp 0", bus.busy); else n_pass++;
      end
      next_cyc();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] wn;
    wn = $urandom;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 32'h300;
    next_cyc();
    drive_idle();
    next_cyc();
    bus.HREADY = 1'b0;
    HRESET = 1'b1;
    @(negedge HCLK);
    n_chk++; if (bus.cmd_ready !== 1'b0) $display("FAIL rm_ready got %b exp 0", bus.cmd_ready); else n_pass++;
    next_cyc();
    HRESET = 1'b0;
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    n_chk++; if (bus.HTRANS !== 2'b00) $display("FAIL rm_htrans got %h exp 0", bus.HTRANS); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rm_busy got %b exp 0", bus.busy); else n_pass++;
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL rm_rsp got %b exp 0", bus.rsp_valid); else n_pass++;
    next_cyc();
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h304;
    bus.cmd_wdata = wn;
    @(negedge HCLK);
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL rm_rsp2 got %b exp 0", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.cmd_ready !== 1'b1) $display("FAIL rm_new_ready got %b exp 1", bus.cmd_ready); else n_pass++;
    next_cyc();
    drive_idle();
    @(negedge HCLK);
    n_chk++; if (bus.HADDR !== 32'h304 || bus.HTRANS !== 2'b10) $display("FAIL rm_new_addr got %h/%h exp 304/2", bus.HADDR, bus.HTRANS); else n_pass++;
    next_cyc();
    @(negedge HCLK);
    n_chk++; if (bus.HWDATA !== wn) $display("FAIL rm_new_wdata got %h exp %h", bus.HWDATA, wn); else n_pass++;
    next_cyc();
    @(negedge HCLK);
    n_chk++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0) $display("FAIL rm_new_rsp got %b/%b exp 1/0", bus.rsp_valid, bus.rsp_error); else n_pass++;
    next_cyc();
  endtask

  task automatic test_random();
    localparam int N = 80;
    cmd_t        cq[$];
    bit          eq[$];
    cmd_t        cur;
    logic [31:0] smem [16];
    logic [31:0] rm [16];
    logic [31:0] exp_rd;
    int          issued = 0;
    int          cap = 0;
    int          rsp = 0;
    int          cyc = 0;
    bit          hs = 0;
    bit          dp_act = 0;
    bit          dp_w = 0;
    logic [31:0] dp_a = '0;
    int          dp_wait = 0;
    int          dp_err = 0;
    int          dp_idx = 0;
    bit          have_prev = 0;
    logic        p_rdy = 1'b1;
    logic        p_resp = 1'b0;
    logic [1:0]  p_tr = 2'b00;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wd = '0;
    logic        p_hw = 1'b0;
    for (int i = 0; i < 16; i++) begin
      smem[i] = 32'hA500_0000 | i;
      rm[i]   = 32'hA500_0000 | i;
    end
    drive_idle();
    while (rsp < N && cyc < 4000) begin
      if (dp_act) begin
        bus.HREADY = (dp_wait == 0 && dp_err != 2);
        bus.HRESP  = (dp_wait == 0 && dp_err != 0);
        bus.HRDATA = smem[dp_a[5:2]];
      end else begin
        bus.HREADY = 1'b1;
        bus.HRESP  = 1'b0;
        bus.HRDATA = $urandom;
      end
      if (hs) bus.cmd_valid = 1'b0;
      if (!bus.cmd_valid && issued < N && $urandom_range(0, 3) != 0) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'($urandom_range(0, 1));
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
      end
      @(negedge HCLK);
      n_chk++;
      if (bus.HSIZE !== 3'b010 || bus.HBURST !== 3'b000 || (bus.HTRANS !== 2'b00 && bus.HTRANS !== 2'b10))
        $display("FAIL rnd_ctrl cyc%0d got %b/%b/%b", cyc, bus.HSIZE, bus.HBURST, bus.HTRANS);
      else n_pass++;
      if (have_prev && !p_rdy) begin
        n_chk++; if (bus.HWDATA !== p_wd) $display("FAIL rnd_hwdata_hold cyc%0d got %h exp %h", cyc, bus.HWDATA, p_wd); else n_pass++;
        if (p_tr == 2'b10) begin
          n_chk++; if (bus.HADDR !== p_addr || bus.HWRITE !== p_hw) $display("FAIL rnd_addr_hold cyc%0d got %h/%b exp %h/%b", cyc, bus.HADDR, bus.HWRITE, p_addr, p_hw); else n_pass++;
          n_chk++; if (bus.HTRANS !== (p_resp ? 2'b00 : 2'b10)) $display("FAIL rnd_trans_hold cyc%0d got %h exp %h", cyc, bus.HTRANS, (p_resp ? 2'b00 : 2'b10)); else n_pass++;
        end
      end
      hs = bus.cmd_valid && bus.cmd_ready;
      if (hs) begin
        cur.w = bus.cmd_write;
        cur.a = bus.cmd_addr;
        cur.d = bus.cmd_wdata;
        cq.push_back(cur);
        issued++;
      end
      if (bus.rsp_valid) begin
        n_chk++;
        if (rsp >= cap) begin
          $display("FAIL rnd_rsp_extra cyc%0d got rsp %0d exp < %0d", cyc, rsp, cap);
        end else begin
          n_pass++;
          cur = cq[rsp];
          exp_rd = cur.w ? 32'h0 : rm[cur.a[5:2]];
          n_chk++; if (bus.rsp_error !== eq[rsp]) $display("FAIL rnd_rsp_err #%0d got %b exp %b", rsp, bus.rsp_error, eq[rsp]); else n_pass++;
          n_chk++; if (bus.rsp_rdata !== exp_rd) $display("FAIL rnd_rsp_rdata #%0d got %h exp %h", rsp, bus.rsp_rdata, exp_rd); else n_pass++;
          if (cur.w && !eq[rsp]) rm[cur.a[5:2]] = cur.d;
        end
        rsp++;
      end
      if (dp_act) begin
        if (dp_wait > 0) dp_wait--;
        else if (dp_err == 2) dp_err = 1;
        else begin
          if (dp_w) begin
            n_chk++; if (bus.HWDATA !== cq[dp_idx].d) $display("FAIL rnd_hwdata #%0d got %h exp %h", dp_idx, bus.HWDATA, cq[dp_idx].d); else n_pass++;
            if (dp_err == 0) smem[dp_a[5:2]] = bus.HWDATA;
          end
          dp_act = 0;
        end
      end
      if (bus.HREADY && bus.HTRANS == 2'b10) begin
        n_chk++;
        if (cap >= cq.size())
          $display("FAIL rnd_extra_xfer cyc%0d got xfer %0d exp < %0d", cyc, cap, cq.size());
        else if (bus.HADDR !== {cq[cap].a[31:2], 2'b00} || bus.HWRITE !== cq[cap].w)
          $display("FAIL rnd_xfer #%0d got %h/%b exp %h/%b", cap, bus.HADDR, bus.HWRITE, {cq[cap].a[31:2], 2'b00}, cq[cap].w);
        else n_pass++;
        dp_act  = 1;
        dp_w    = bus.HWRITE;
        dp_a    = bus.HADDR;
        dp_idx  = cap;
        dp_wait = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 3));
        dp_err  = ($urandom_range(0, 4) == 0) ? 2 : 0;
        eq.push_back(dp_err != 0);
        cap++;
      end
      p_rdy  = bus.HREADY;
      p_resp = bus.HRESP;
      p_tr   = bus.HTRANS;
      p_addr = bus.HADDR;
      p_hw   = bus.HWRITE;
      p_wd   = bus.HWDATA;
      have_prev = 1;
      next_cyc();
      cyc++;
    end
    drive_idle();
    n_chk++; if (rsp != N) $display("FAIL rnd_timeout got %0d responses exp %0d", rsp, N); else n_pass++;
    @(negedge HCLK);
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rnd_busy_end got %b exp 0", bus.busy); else n_pass++;
    next_cyc();
  endtask

  initial begin
    HRESET = 1'b1;
    drive_idle();
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
